// File: rtl/parking_occupancy_tracker.sv
// Multi-lane parking occupancy counter with saturating update, sticky range errors
// and an OPEN/NEAR/FULL sign-status FSM with exit hysteresis.
module parking_occupancy_tracker #(
    parameter int WIDTH      = 8,
    parameter int CAPACITY   = 200,
    parameter int N_LANES    = 2,
    parameter int NEAR_LEVEL = 190,
    parameter int HYST       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] inc,
    input  logic [N_LANES-1:0] dec,
    input  logic               load_en,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               err_clear,
    output logic [WIDTH-1:0]   occupancy,
    output logic [1:0]         status,
    output logic               full,
    output logic               empty,
    output logic               overflow_err,
    output logic               underflow_err
);

    localparam int SW = WIDTH + 2;
    localparam logic [WIDTH-1:0]     CAP_W  = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0]     NEAR_W = WIDTH'(NEAR_LEVEL);
    localparam logic [WIDTH-1:0]     REL_W  = WIDTH'(CAPACITY - HYST);
    localparam logic signed [SW-1:0] CAP_S  = SW'(CAPACITY);

    typedef enum logic [1:0] {
        ST_OPEN = 2'b00,
        ST_NEAR = 2'b01,
        ST_FULL = 2'b10
    } status_t;

    status_t            state, state_nxt;
    logic [WIDTH-1:0]   occ_nxt;
    logic               ovf_nxt, udf_nxt;
    logic signed [SW-1:0] net, sum_s;

    function automatic logic [SW-1:0] popcount(input logic [N_LANES-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < N_LANES; i++) c = c + SW'(v[i]);
        return c;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        occ_nxt   = occupancy;
        ovf_nxt   = overflow_err & ~err_clear;
        udf_nxt   = underflow_err & ~err_clear;
        state_nxt = state;
        net       = $signed(popcount(inc)) - $signed(popcount(dec));
        sum_s     = $signed({2'b00, occupancy}) + net;

        if (load_en) begin
            occ_nxt = (load_val > CAP_W) ? CAP_W : load_val;
        end else if (sum_s > CAP_S) begin
            occ_nxt = CAP_W;
            ovf_nxt = 1'b1;
        end else if (sum_s[SW-1]) begin
            occ_nxt = '0;
            udf_nxt = 1'b1;
        end else begin
            occ_nxt = sum_s[WIDTH-1:0];
        end

        // Transitions look at the value being written this edge, not the stale count.
        unique case (state)
            ST_OPEN: begin
                if (occ_nxt >= CAP_W)       state_nxt = ST_FULL;
                else if (occ_nxt >= NEAR_W) state_nxt = ST_NEAR;
            end
            ST_NEAR: begin
                if (occ_nxt >= CAP_W)      state_nxt = ST_FULL;
                else if (occ_nxt < NEAR_W) state_nxt = ST_OPEN;
            end
            ST_FULL: begin
                if (occ_nxt <= REL_W) state_nxt = (occ_nxt >= NEAR_W) ? ST_NEAR : ST_OPEN;
            end
            default: state_nxt = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all state updating from pre-edge values.
        if (reset) begin
            state         <= ST_OPEN;
            occupancy     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            occupancy     <= occ_nxt;
            overflow_err  <= ovf_nxt;
            underflow_err <= udf_nxt;
        end
    end

    assign status = state;
    assign full   = (state == ST_FULL);
    assign empty  = (occupancy == '0);

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Directed bench for parking_occupancy_tracker; each comparison checks the packed
// output word {occupancy, status, full, empty, overflow_err, underflow_err}.
module tb_parking_occupancy_tracker;

    localparam logic [1:0] OPEN = 2'b00;
    localparam logic [1:0] NEAR = 2'b01;
    localparam logic [1:0] FULL = 2'b10;

    logic       clk = 1'b0;
    logic       reset, load_en, err_clear;
    logic [1:0] inc, dec;
    logic [7:0] load_val;
    logic [7:0] occupancy;
    logic [1:0] status;
    logic       full, empty, overflow_err, underflow_err;
    logic [13:0] obs, exp;
    int errors = 0;
    int checks = 0;

    parking_occupancy_tracker dut (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec),
        .load_en(load_en), .load_val(load_val), .err_clear(err_clear),
        .occupancy(occupancy), .status(status), .full(full), .empty(empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    assign obs = {occupancy, status, full, empty, overflow_err, underflow_err};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; inc = 2'b00; dec = 2'b00;
        load_en = 1'b0; load_val = 8'd0; err_clear = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        load_en = 1'b1; load_val = v;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; inc = 2'b11;
        tick();
        tick();
        idle();
        exp = {8'd0, OPEN, 4'b0100};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, exp); end
    endtask

    task automatic test_count();
        inc = 2'b11;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = {8'(2 * i), OPEN, 4'b0000};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL count_step%0d: got %h expected %h", i, obs, exp); end
        end
        inc = 2'b00;
    endtask

    task automatic test_near();
        load(8'd189);
        exp = {8'd189, OPEN, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL near_below: got %h expected %h", obs, exp); end
        inc = 2'b01; tick(); inc = 2'b00;
        exp = {8'd190, NEAR, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL near_enter: got %h expected %h", obs, exp); end
        dec = 2'b01; tick(); dec = 2'b00;
        exp = {8'd189, OPEN, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL near_leave: got %h expected %h", obs, exp); end
    endtask

    task automatic test_overflow();
        load(8'd199);
        exp = {8'd199, NEAR, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ovf_load199: got %h expected %h", obs, exp); end
        inc = 2'b01; tick();
        exp = {8'd200, FULL, 4'b1000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ovf_reach_full: got %h expected %h", obs, exp); end
        inc = 2'b11; tick(); inc = 2'b00;
        exp = {8'd200, FULL, 4'b1010};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ovf_saturate: got %h expected %h", obs, exp); end
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ovf_sticky: got %h expected %h", obs, exp); end
    endtask

    task automatic test_hysteresis();
        dec = 2'b01; tick();
        exp = {8'd199, FULL, 4'b1010};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL hyst_hold: got %h expected %h", obs, exp); end
        tick(); dec = 2'b00;
        exp = {8'd198, NEAR, 4'b0010};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL hyst_release: got %h expected %h", obs, exp); end
    endtask

    task automatic test_set_wins();
        load(8'd200);
        inc = 2'b01; err_clear = 1'b1; tick();
        inc = 2'b00; err_clear = 1'b0;
        exp = {8'd200, FULL, 4'b1010};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL set_wins_clear: got %h expected %h", obs, exp); end
    endtask

    task automatic test_underflow();
        load(8'd1);
        exp = {8'd1, OPEN, 4'b0010};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL udf_load1: got %h expected %h", obs, exp); end
        dec = 2'b11; tick(); dec = 2'b00;
        exp = {8'd0, OPEN, 4'b0111};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL udf_saturate: got %h expected %h", obs, exp); end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        exp = {8'd0, OPEN, 4'b0100};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL err_clear: got %h expected %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        load(8'd50);
        exp = {8'd50, OPEN, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL net_load50: got %h expected %h", obs, exp); end
        inc = 2'b11; dec = 2'b01; tick();
        exp = {8'd51, OPEN, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL net_plus1: got %h expected %h", obs, exp); end
        inc = 2'b01; dec = 2'b01; tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL net_zero: got %h expected %h", obs, exp); end
        inc = 2'b00; dec = 2'b11; tick(); dec = 2'b00;
        exp = {8'd49, OPEN, 4'b0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL net_minus2: got %h expected %h", obs, exp); end
    endtask

    task automatic test_load_clamp();
        inc = 2'b11;
        load(8'd255);
        inc = 2'b00;
        exp = {8'd200, FULL, 4'b1000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL load_clamp: got %h expected %h", obs, exp); end
        reset = 1'b1; inc = 2'b11; tick();
        idle();
        exp = {8'd0, OPEN, 4'b0100};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_midburst: got %h expected %h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_near();
        test_overflow();
        test_hysteresis();
        test_set_wins();
        test_underflow();
        test_back_to_back();
        test_load_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
